// File: rtl/vend_controller.sv
// vend_controller
//   Sequencer for the three-item nickel/dime vending machine. It latches the
//   item selection and accumulates coin credit against that item's price.
//   It then handshakes with the dispense mechanism and finally returns change
//   or refunds one nickel per cycle. Cancel or an inactivity timeout in
//   COLLECT aborts the sale into a refund. All outputs are registered.
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   synchronous, active-high
//   select_valid in   selection strobe, sampled only in IDLE
//   select       in   [1:0] item code 1..3 (0 ignored)
//   nickel_in    in   one-cycle pulse per nickel inserted
//   dime_in      in   one-cycle pulse per dime inserted
//   cancel       in   customer cancel, honoured only in COLLECT
//   vend_ack     in   dispense mechanism completion
//   vend         out  [2:0] one-hot dispense request, bit i-1 = item i
//   nickel_out   out  one nickel ejected per high cycle
//   coin_reject  out  the coin sampled on the previous edge was bounced
//   credit       out  [3:0] accumulated credit in nickels
//   item         out  [1:0] latched item code, 0 in IDLE
//   busy         out  high whenever the machine is not in IDLE
module vend_controller #(
  parameter int PRICE_1 = 3,
  parameter int PRICE_2 = 4,
  parameter int PRICE_3 = 5,
  parameter int TIMEOUT = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       select_valid,
  input  logic [1:0] select,
  input  logic       nickel_in,
  input  logic       dime_in,
  input  logic       cancel,
  input  logic       vend_ack,
  output logic [2:0] vend,
  output logic       nickel_out,
  output logic       coin_reject,
  output logic [3:0] credit,
  output logic [1:0] item,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_DISPENSE,
    S_CHANGE,
    S_REFUND
  } state_t;

  state_t          state, state_next;
  logic [3:0]      remaining, remaining_next;
  logic [TW-1:0]   timer, timer_next, timer_inc;
  logic [3:0]      credit_next, coin_credit, change_due;
  logic [2:0]      vend_next;
  logic [1:0]      item_next;
  logic            nickel_next, reject_next, busy_next, coin_any;

  function automatic logic [3:0] price_of(input logic [1:0] code);
    case (code)
      2'd1:    return 4'(PRICE_1);
      2'd2:    return 4'(PRICE_2);
      default: return 4'(PRICE_3);
    endcase
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] code);
    case (code)
      2'd1:    return 3'b001;
      2'd2:    return 3'b010;
      2'd3:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // A dime always wins over a simultaneous nickel, so only one coin is
  // ever credited per cycle.
  assign coin_any    = nickel_in | dime_in;
  assign coin_credit = credit + (dime_in ? 4'd2 : {3'b000, nickel_in});
  assign timer_inc   = timer + TW'(1);
  assign change_due  = credit - price_of(item);

  always_comb begin
    state_next     = state;
    item_next      = item;
    credit_next    = credit;
    remaining_next = remaining;
    timer_next     = timer;
    vend_next      = 3'b000;
    nickel_next    = 1'b0;
    reject_next    = 1'b0;

    case (state)
      S_IDLE: begin
        reject_next = coin_any;
        if (select_valid && select != 2'd0) begin
          state_next  = S_COLLECT;
          item_next   = select;
          credit_next = 4'd0;
          timer_next  = '0;
        end
      end

      S_COLLECT: begin
        reject_next = nickel_in & dime_in;
        if (coin_any) begin
          credit_next = coin_credit;
          timer_next  = '0;
        end else begin
          timer_next  = timer_inc;
        end
        // A completing coin beats a simultaneous cancel or timeout.
        if (coin_any && coin_credit >= price_of(item)) begin
          state_next = S_DISPENSE;
          vend_next  = onehot(item);
        end else if (cancel || (!coin_any && timer_inc == TW'(TIMEOUT))) begin
          if (credit_next == 4'd0) begin
            // Nothing to hand back: skip the refund state entirely.
            state_next     = S_IDLE;
            item_next      = 2'd0;
            remaining_next = 4'd0;
          end else begin
            state_next     = S_REFUND;
            remaining_next = credit_next;
            nickel_next    = 1'b1;
          end
        end
      end

      S_DISPENSE: begin
        reject_next = coin_any;
        vend_next   = onehot(item);
        if (vend_ack) begin
          vend_next   = 3'b000;
          credit_next = 4'd0;
          if (change_due != 4'd0) begin
            state_next     = S_CHANGE;
            remaining_next = change_due;
            nickel_next    = 1'b1;
          end else begin
            state_next     = S_IDLE;
            item_next      = 2'd0;
            remaining_next = 4'd0;
          end
        end
      end

      S_CHANGE, S_REFUND: begin
        reject_next    = coin_any;
        remaining_next = remaining - 4'd1;
        if (state == S_REFUND) begin
          credit_next = remaining - 4'd1;
        end
        if (remaining_next == 4'd0) begin
          state_next  = S_IDLE;
          item_next   = 2'd0;
          credit_next = 4'd0;
        end else begin
          nickel_next = 1'b1;
        end
      end

      default: begin
        state_next     = S_IDLE;
        item_next      = 2'd0;
        credit_next    = 4'd0;
        remaining_next = 4'd0;
      end
    endcase

    busy_next = (state_next != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      item        <= 2'd0;
      credit      <= 4'd0;
      remaining   <= 4'd0;
      timer       <= '0;
      vend        <= 3'b000;
      nickel_out  <= 1'b0;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_next;
      item        <= item_next;
      credit      <= credit_next;
      remaining   <= remaining_next;
      timer       <= timer_next;
      vend        <= vend_next;
      nickel_out  <= nickel_next;
      coin_reject <= reject_next;
      busy        <= busy_next;
    end
  end

endmodule

// File: doc/vend_controller.md
# vend_controller

Top-level sequencer for the three-item nickel/dime vending machine. It latches the customer's item selection, accumulates coin credit against that item's price, and runs a handshake with the dispense mechanism. It then returns change or refunds one nickel per cycle, and aborts on cancel or inactivity timeout. It owns the shared coin path and the single nickel-return chute that the per-item price FSMs would otherwise each drive.

## Interface
- PRICE_1, default 3: item 1 price in nickels (15c).
- PRICE_2, default 4: item 2 price in nickels (20c).
- PRICE_3, default 5: item 3 price in nickels (25c).
- TIMEOUT, default 255: COLLECT cycles without an accepted coin before auto-refund; must be ≥2.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- select_valid  in  1  selection strobe, sampled only in IDLE.
- select  in  2  item code: 1, 2 or 3; 0 is ignored.
- nickel_in  in  1  one-cycle pulse per nickel inserted.
- dime_in  in  1  one-cycle pulse per dime inserted.
- cancel  in  1  customer cancel, honoured only in COLLECT.
- vend_ack  in  1  dispense mechanism completion.
- vend  out  3  one-hot item dispense request; bit i-1 = item i.
- nickel_out  out  1  one nickel ejected per high cycle.
- coin_reject  out  1  pulse: the coin sampled last cycle was bounced.
- credit  out  4  accumulated credit in nickels.
- item  out  2  latched item code; 0 in IDLE.
- busy  out  1  high when state ≠ IDLE.

## Operation
- States: IDLE, COLLECT, DISPENSE, CHANGE, REFUND.
- All outputs are registered.
  - On reset: state=IDLE, vend=0, nickel_out=0, coin_reject=0, credit=0, item=0, busy=0, timeout counter=0.
- **IDLE**
  - select_valid with select∈{1,2,3}: latch item, credit=0, timer=0, go to COLLECT.
  - select=0 is ignored.
  - Any coin pulse in IDLE: coin_reject=1 next cycle; credit is unchanged.
- **COLLECT**
  - Dime: credit+=2. Nickel: credit+=1.
  - Nickel and dime in the same cycle: the dime is accepted and the nickel rejected (coin_reject=1).
  - Each accepted coin clears the timer. Otherwise the timer increments each cycle.
  - If the accepted coin makes credit ≥ price(item), go to DISPENSE on that same edge.
  - Maximum credit is price+1 (a dime on price−1). Credit width of 4 bits is sufficient; no saturation logic is needed.
  - cancel (with no coin completing the price): go to REFUND with remaining=credit.
  - If a coin completes the price in the same cycle as cancel, the dispense wins.
  - Timer reaching TIMEOUT: go to REFUND, same as cancel.
  - select_valid is ignored in COLLECT.
- **DISPENSE**
  - vend=onehot(item), held until vend_ack is sampled.
  - On vend_ack: remaining=credit−price (0 or 1), credit=0.
  - Next state is CHANGE if remaining>0, else IDLE.
  - In DISPENSE, coins are rejected and cancel is ignored.
- **CHANGE / REFUND**
  - nickel_out=1 every cycle in state; remaining decrements each cycle; credit mirrors remaining in REFUND.
  - Exit to IDLE on the edge where remaining goes 1→0.
  - A REFUND entered with credit=0 exits to IDLE immediately, with no nickel_out.
  - Coins arriving in these states are rejected.
- Leaving to IDLE clears item and credit.
- Reset mid-operation aborts with no refund. This is intentional: the operator recovers coins from the machine.

## Timing
- Coin sampled at edge t: credit is updated after edge t. coin_reject is high for cycle t+1 only.
- Price reached at edge t: vend is high from t+1.
- vend_ack sampled at edge t: vend drops at t+1.
  - If change is due, nickel_out is high from t+1 for exactly one cycle.
- vend_ack outside DISPENSE is ignored.
- REFUND of N nickels: nickel_out is high for exactly N consecutive cycles, then busy drops on the next edge.
- Timeout fires on the TIMEOUT-th consecutive COLLECT cycle with no accepted coin.

## Test plan
- Item 1, nickel,nickel,nickel → vend=001 after the 3rd coin; ack → IDLE, nickel_out never asserted.
- Item 3, dime,dime,dime → credit 2,4,6; vend=100; ack → nickel_out exactly 1 cycle; busy drops.
- Item 2, dime + simultaneous nickel/dime pair → credit=4, coin_reject pulse once, vend=010.
- Item 2, dime, then cancel → REFUND, nickel_out high 2 consecutive cycles, credit 2→1→0, IDLE.
- TIMEOUT=8, item 1, nickel, then idle for 8 cycles → REFUND with 1 nickel; coin in IDLE → coin_reject only.
- Reset asserted in CHANGE and in DISPENSE → all outputs 0 the next cycle; select=0 in IDLE ignored.
